// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART TX arbiter files.
//   NUM_REQ_MAX : upper bound on the number of requesters (legal range 1..8)
//   state_t     : arbiter FSM encoding. ST_HDR is only reachable when the
//                 arbiter is built with UART_TX_ARB_HDR_EN.
package uart_pkg;

  localparam int NUM_REQ_MAX = 8;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_SEND_ENC = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC = 2'd2;
  localparam logic [1:0] ST_HDR_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_SEND = ST_SEND_ENC,
    ST_WAIT = ST_WAIT_ENC,
    ST_HDR  = ST_HDR_ENC
  } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
//   REQ_VALID : per-requester request flags
//   rr_ptr    : index where the search starts (searching upward, wrapping)
//   idx       : first valid index at or above rr_ptr (modulo NUM_REQ)
//   any_valid : at least one request is present; idx is meaningless otherwise
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] REQ_VALID,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  int cand;

  always_comb begin
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      // First hit wins; later candidates are ignored once any_valid is set.
      if (!any_valid && REQ_VALID[IDX_W'(cand)]) begin
        idx       = IDX_W'(cand);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte-stream
// requesters. One requester owns the transmitter for a whole message (first
// accepted byte through the byte flagged REQ_LAST); owners rotate round-robin.
// Each byte is started with a one-cycle TX_DRDY pulse and the next byte is not
// offered until the UART reports TX_DONE.
//
// Build option: define UART_TX_ARB_HDR_EN to precede every message with one
// header byte holding the grant index (zero-extended). Default build has no
// header.
//
// Ports:
//   CLK, RST   : clock, asynchronous active-high reset
//   REQ_VALID  : requester i has a byte on REQ_DATA[i*DATA_BITS +: DATA_BITS]
//   REQ_DATA   : packed requester bytes
//   REQ_LAST   : current byte of requester i ends its message
//   REQ_READY  : byte of the granted requester accepted this cycle
//   GRANT      : one-hot transmitter owner, zero when idle
//   TX_DI      : registered byte to the UART
//   TX_DRDY    : registered one-cycle start pulse to the UART
//   TX_BUSY    : UART transmitter busy
//   TX_DONE    : UART frame-complete pulse
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           REQ_VALID,
  input  logic [NUM_REQ*DATA_BITS-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]           REQ_LAST,
  output logic [NUM_REQ-1:0]           REQ_READY,
  output logic [NUM_REQ-1:0]           GRANT,
  output logic [DATA_BITS-1:0]         TX_DI,
  output logic                         TX_DRDY,
  input  logic                         TX_BUSY,
  input  logic                         TX_DONE
);

  state_t               state;
  logic [IDX_W-1:0]     g_idx;
  logic [IDX_W-1:0]     rr_ptr;
  logic                 last_q;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [IDX_W-1:0]     next_ptr;
  logic [DATA_BITS-1:0] sel_data;
  logic                 sel_last;
  logic                 handshake;
`ifdef UART_TX_ARB_HDR_EN
  logic                 hdr_issued;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .REQ_VALID (REQ_VALID),
    .rr_ptr    (rr_ptr),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  // Ready only reaches the owner, and only while the UART can take a byte.
  assign REQ_READY = (state == ST_SEND && !TX_BUSY) ? GRANT : '0;
  assign handshake = |(REQ_VALID & REQ_READY);
  assign next_ptr  = (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

  // GRANT is one-hot, so an OR-style mux selects the owner's byte and flag.
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GRANT[i]) begin
        sel_data = REQ_DATA[i*DATA_BITS +: DATA_BITS];
        sel_last = REQ_LAST[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      GRANT      <= '0;
      g_idx      <= '0;
      rr_ptr     <= '0;
      last_q     <= 1'b0;
      TX_DI      <= '0;
      TX_DRDY    <= 1'b0;
`ifdef UART_TX_ARB_HDR_EN
      hdr_issued <= 1'b0;
`endif
    end else begin
      TX_DRDY <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            g_idx <= pick_idx;
            GRANT <= NUM_REQ'(1) << pick_idx;
`ifdef UART_TX_ARB_HDR_EN
            state <= ST_HDR;
`else
            state <= ST_SEND;
`endif
          end
        end
`ifdef UART_TX_ARB_HDR_EN
        // Header is started once, then held here until its frame completes.
        ST_HDR: begin
          if (!hdr_issued) begin
            if (!TX_BUSY) begin
              TX_DI      <= DATA_BITS'(g_idx);
              TX_DRDY    <= 1'b1;
              hdr_issued <= 1'b1;
            end
          end else if (TX_DONE) begin
            hdr_issued <= 1'b0;
            state      <= ST_SEND;
          end
        end
`endif
        // Grant is held here indefinitely if the owner stalls mid-message.
        ST_SEND: begin
          if (handshake) begin
            TX_DI   <= sel_data;
            TX_DRDY <= 1'b1;
            last_q  <= sel_last;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (TX_DONE) begin
            if (last_q) begin
              GRANT  <= '0;
              rr_ptr <= next_ptr;
              state  <= ST_IDLE;
            end else begin
              state  <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester byte feeders, a UART model that
// answers each TX_DRDY with a FRAME-cycle busy period and a TX_DONE pulse, and
// a scoreboard of expected TX bytes filled when messages are queued.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_BITS = 8;
  localparam int FRAME     = 4;
`ifdef UART_TX_ARB_HDR_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  logic                         CLK = 1'b0;
  logic                         RST = 1'b1;
  logic [NUM_REQ-1:0]           REQ_VALID = '0;
  logic [NUM_REQ*DATA_BITS-1:0] REQ_DATA = '0;
  logic [NUM_REQ-1:0]           REQ_LAST = '0;
  logic [NUM_REQ-1:0]           REQ_READY;
  logic [NUM_REQ-1:0]           GRANT;
  logic [DATA_BITS-1:0]         TX_DI;
  logic                         TX_DRDY;
  logic                         TX_BUSY;
  logic                         TX_DONE = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]         exp_q[$];
  logic [7:0]         msg_data [NUM_REQ][8];
  int                 msg_len [NUM_REQ];
  int                 msg_pos [NUM_REQ];
  logic [NUM_REQ-1:0] hold = '0;
  logic               uart_busy = 1'b0;
  logic               busy_force = 1'b0;
  int                 uart_cnt = 0;
  int                 drdy_cnt = 0;
  int                 done_cnt = 0;
  logic [NUM_REQ-1:0] prev_grant = '0;
  logic               hdr_pending = 1'b0;

  assign TX_BUSY = uart_busy | busy_force;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_LAST  (REQ_LAST),
    .REQ_READY (REQ_READY),
    .GRANT     (GRANT),
    .TX_DI     (TX_DI),
    .TX_DRDY   (TX_DRDY),
    .TX_BUSY   (TX_BUSY),
    .TX_DONE   (TX_DONE)
  );

  // UART model, scoreboard consumer and requester feeders, 1 time unit after
  // each rising edge. A TX_DRDY seen here was caused by the edge just passed.
  always begin
    logic [7:0] exp;
    @(posedge CLK);
    #1;
    TX_DONE = 1'b0;
    if (TX_DRDY) begin
      drdy_cnt++;
      vectors++;
      if (uart_busy) begin
        miscompares++;
        $display("FAIL drdy_while_busy: TX_DRDY=1 during frame, required 0");
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_byte: TX_DI=%h, required no transmission", TX_DI);
      end else begin
        exp = exp_q.pop_front();
        if (TX_DI !== exp) begin
          miscompares++;
          $display("FAIL tx_byte: TX_DI=%h, required %h", TX_DI, exp);
        end
      end
      if (hdr_pending) begin
        hdr_pending = 1'b0;
      end else begin
        for (int i = 0; i < NUM_REQ; i++)
          if (GRANT[i] && msg_pos[i] < msg_len[i]) msg_pos[i]++;
      end
      uart_busy = 1'b1;
      uart_cnt  = FRAME;
    end else if (uart_busy) begin
      uart_cnt--;
      if (uart_cnt == 0) begin
        uart_busy = 1'b0;
        TX_DONE   = 1'b1;
        done_cnt++;
      end
    end
`ifdef UART_TX_ARB_HDR_EN
    if (prev_grant == '0 && GRANT != '0) hdr_pending = 1'b1;
`endif
    prev_grant = GRANT;
    if (RST) hdr_pending = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (msg_pos[i] < msg_len[i] && !hold[i]) begin
        REQ_VALID[i] = 1'b1;
        REQ_DATA[i*DATA_BITS +: DATA_BITS] = msg_data[i][msg_pos[i]];
        REQ_LAST[i] = (msg_pos[i] == msg_len[i] - 1);
      end else begin
        REQ_VALID[i] = 1'b0;
        REQ_DATA[i*DATA_BITS +: DATA_BITS] = '0;
        REQ_LAST[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_msgs();
    for (int i = 0; i < NUM_REQ; i++) begin
      msg_len[i] = 0;
      msg_pos[i] = 0;
    end
    hold       = '0;
    busy_force = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_msgs();
    repeat (3) tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic load_msg(input int r, input int n, input logic [7:0] base);
    for (int j = 0; j < n; j++) msg_data[r][j] = base + 8'(j);
    msg_pos[r] = 0;
    msg_len[r] = n;
  endtask

  task automatic expect_msg(input int r, input int n, input logic [7:0] base);
    if (HDR_BYTES != 0) exp_q.push_back(8'(r));
    for (int j = 0; j < n; j++) exp_q.push_back(base + 8'(j));
  endtask

  function automatic bit all_sent();
    for (int i = 0; i < NUM_REQ; i++)
      if (msg_pos[i] < msg_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (!(all_sent() && GRANT == '0 && !uart_busy) && cyc < 3000) begin
      tick();
      cyc++;
    end
    vectors++;
    if (cyc >= 3000) begin
      miscompares++;
      $display("FAIL %s_timeout: GRANT=%b after %0d cycles, required idle", name, GRANT, cyc);
    end
  endtask

  task automatic wait_drdy(input string name, input int target);
    int cyc = 0;
    while (drdy_cnt < target && cyc < 200) begin
      tick();
      cyc++;
    end
    vectors++;
    if (cyc >= 200) begin
      miscompares++;
      $display("FAIL %s_drdy_timeout: drdy_cnt=%0d, required %0d", name, drdy_cnt, target);
    end
  endtask

  task automatic wait_grant(input string name, input logic [NUM_REQ-1:0] g);
    int cyc = 0;
    while (GRANT !== g && cyc < 50) begin
      tick();
      cyc++;
    end
    vectors++;
    if (GRANT !== g) begin
      miscompares++;
      $display("FAIL %s_grant: GRANT=%b, required %b", name, GRANT, g);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    vectors++;
    if (GRANT !== '0) begin miscompares++; $display("FAIL reset_grant: GRANT=%b, required 0", GRANT); end
    vectors++;
    if (REQ_READY !== '0) begin miscompares++; $display("FAIL reset_ready: REQ_READY=%b, required 0", REQ_READY); end
    vectors++;
    if (TX_DRDY !== 1'b0) begin miscompares++; $display("FAIL reset_drdy: TX_DRDY=%b, required 0", TX_DRDY); end
    vectors++;
    if (TX_DI !== '0) begin miscompares++; $display("FAIL reset_di: TX_DI=%h, required 00", TX_DI); end
    vectors++;
    if (dut.rr_ptr !== 2'd0) begin miscompares++; $display("FAIL reset_rr_ptr: rr_ptr=%0d, required 0", dut.rr_ptr); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int d0;
    int n0;
    do_reset();
    d0 = drdy_cnt;
    n0 = done_cnt;
    load_msg(0, 3, 8'h41);
    expect_msg(0, 3, 8'h41);
    tick();
    tick();
    vectors++;
    if (GRANT !== 4'b0001) begin miscompares++; $display("FAIL single_grant_lat: GRANT=%b, required 0001", GRANT); end
`ifndef UART_TX_ARB_HDR_EN
    vectors++;
    if (REQ_READY !== 4'b0001) begin miscompares++; $display("FAIL single_ready_lat: REQ_READY=%b, required 0001", REQ_READY); end
    tick();
    vectors++;
    if (TX_DRDY !== 1'b1 || TX_DI !== 8'h41) begin
      miscompares++;
      $display("FAIL single_drdy_lat: TX_DRDY=%b TX_DI=%h, required 1 41", TX_DRDY, TX_DI);
    end
`endif
    wait_idle("single");
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_left: %0d bytes unsent, required 0", exp_q.size()); end
    vectors++;
    if (drdy_cnt - d0 != 3 + HDR_BYTES || done_cnt - n0 != 3 + HDR_BYTES) begin
      miscompares++;
      $display("FAIL single_count: drdy=%0d done=%0d, required %0d each", drdy_cnt - d0, done_cnt - n0, 3 + HDR_BYTES);
    end
    vectors++;
    if (dut.rr_ptr !== 2'd1) begin miscompares++; $display("FAIL single_rr_ptr: rr_ptr=%0d, required 1", dut.rr_ptr); end
  endtask

  task automatic test_round_robin();
    RST = 1'b1;
    clear_msgs();
    load_msg(0, 2, 8'hA0);
    load_msg(2, 2, 8'hC0);
    expect_msg(0, 2, 8'hA0);
    expect_msg(2, 2, 8'hC0);
    tick();
    tick();
    RST = 1'b0;
    wait_idle("rr1");
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rr1_left: %0d bytes unsent, required 0", exp_q.size()); end
    vectors++;
    if (dut.rr_ptr !== 2'd3) begin miscompares++; $display("FAIL rr1_rr_ptr: rr_ptr=%0d, required 3", dut.rr_ptr); end
    load_msg(0, 2, 8'hA8);
    load_msg(2, 2, 8'hC8);
    expect_msg(0, 2, 8'hA8);
    expect_msg(2, 2, 8'hC8);
    wait_idle("rr2");
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rr2_left: %0d bytes unsent, required 0", exp_q.size()); end
    vectors++;
    if (dut.rr_ptr !== 2'd3) begin miscompares++; $display("FAIL rr2_rr_ptr: rr_ptr=%0d, required 3", dut.rr_ptr); end
  endtask

  task automatic test_hold();
    int d0;
    do_reset();
    d0 = drdy_cnt;
    load_msg(1, 3, 8'hB0);
    expect_msg(1, 3, 8'hB0);
    wait_grant("hold", 4'b0010);
    load_msg(0, 1, 8'hD0);
    expect_msg(0, 1, 8'hD0);
    wait_drdy("hold", d0 + 1 + HDR_BYTES);
    hold[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if (GRANT !== 4'b0010 || REQ_READY[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: GRANT=%b REQ_READY=%b, required 0010 with bit0 low", c, GRANT, REQ_READY);
      end
    end
    hold[1] = 1'b0;
    wait_idle("hold");
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL hold_left: %0d bytes unsent, required 0", exp_q.size()); end
    vectors++;
    if (dut.rr_ptr !== 2'd1) begin miscompares++; $display("FAIL hold_rr_ptr: rr_ptr=%0d, required 1", dut.rr_ptr); end
  endtask

  task automatic test_busy();
    do_reset();
    busy_force = 1'b1;
    load_msg(3, 1, 8'hE0);
    expect_msg(3, 1, 8'hE0);
    wait_grant("busy", 4'b1000);
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (REQ_READY !== '0 || TX_DRDY !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_cycle%0d: REQ_READY=%b TX_DRDY=%b, required 0000 0", c, REQ_READY, TX_DRDY);
      end
    end
    busy_force = 1'b0;
`ifndef UART_TX_ARB_HDR_EN
    #1;
    vectors++;
    if (REQ_READY !== 4'b1000) begin miscompares++; $display("FAIL busy_release_ready: REQ_READY=%b, required 1000", REQ_READY); end
    tick();
    vectors++;
    if (TX_DRDY !== 1'b1 || TX_DI !== 8'hE0) begin
      miscompares++;
      $display("FAIL busy_release_drdy: TX_DRDY=%b TX_DI=%h, required 1 e0", TX_DRDY, TX_DI);
    end
`endif
    wait_idle("busy");
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL busy_left: %0d bytes unsent, required 0", exp_q.size()); end
  endtask

  task automatic test_rst_wait();
    int d0;
    int n0;
    int act;
    do_reset();
    d0 = drdy_cnt;
    load_msg(0, 2, 8'hF0);
    if (HDR_BYTES != 0) exp_q.push_back(8'h00);
    exp_q.push_back(8'hF0);
    wait_drdy("rstw", d0 + 1 + HDR_BYTES);
    n0 = done_cnt;
    tick();
    RST = 1'b1;
    #1;
    vectors++;
    if (GRANT !== '0) begin miscompares++; $display("FAIL rstw_grant: GRANT=%b, required 0", GRANT); end
    vectors++;
    if (REQ_READY !== '0) begin miscompares++; $display("FAIL rstw_ready: REQ_READY=%b, required 0", REQ_READY); end
    vectors++;
    if (TX_DRDY !== 1'b0) begin miscompares++; $display("FAIL rstw_drdy: TX_DRDY=%b, required 0", TX_DRDY); end
    vectors++;
    if (TX_DI !== '0) begin miscompares++; $display("FAIL rstw_di: TX_DI=%h, required 00", TX_DI); end
    msg_len[0] = 0;
    msg_pos[0] = 0;
    tick();
    RST = 1'b0;
    act = 0;
    repeat (FRAME + 10) begin
      tick();
      if (TX_DRDY !== 1'b0 || GRANT !== '0) act++;
    end
    vectors++;
    if (act != 0) begin miscompares++; $display("FAIL rstw_activity: %0d active cycles, required 0", act); end
    vectors++;
    if (done_cnt == n0) begin miscompares++; $display("FAIL rstw_stray_done: done pulses=%0d, required at least 1", done_cnt - n0); end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rstw_left: %0d bytes unsent, required 0", exp_q.size()); end
  endtask

`ifdef UART_TX_ARB_HDR_EN
  task automatic test_hdr();
    int d0;
    do_reset();
    d0 = drdy_cnt;
    load_msg(3, 1, 8'h7E);
    expect_msg(3, 1, 8'h7E);
    wait_idle("hdr");
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL hdr_left: %0d bytes unsent, required 0", exp_q.size()); end
    vectors++;
    if (drdy_cnt - d0 != 2) begin miscompares++; $display("FAIL hdr_count: drdy=%0d, required 2", drdy_cnt - d0); end
  endtask
`endif

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      msg_len[i] = 0;
      msg_pos[i] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_busy();
    test_rst_wait();
`ifdef UART_TX_ARB_HDR_EN
    test_hdr();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
